// File: rtl/fhg_tx_pkt_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter's source side (N lanes packed side by side)
// and its single output lane.
interface fhg_tx_pkt_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = 128
) ();
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tlast;
    logic [N-1:0]            tuser;
    logic [N-1:0]            tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/fhg_tx_pkt_arbiter.sv
// Packet-granular round-robin scheduler feeding the DCMAC TX adapter from N_SRC AXIS sources,
// with forced inter-packet idle gaps, almost-full gating and packet/underrun statistics.
module fhg_tx_pkt_arbiter #(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = 128,
    parameter int IPG_CYC    = 1,
    localparam int GW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [5:0]            dcmac_tx_af,
    fhg_tx_pkt_arbiter_if.slave   s,
    fhg_tx_pkt_arbiter_if.master  m,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           underrun_cnt,
    output logic [1:0]            fsm_state
);
    localparam int GCW = $clog2(IPG_CYC + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, GAP = 2'd2} state_t;

    // Handshake: a beat moves on a port in any cycle where tvalid and tready are both 1;
    // s.tready is only ever raised for the granted source while in XFER.
    state_t                  state;
    logic [GW-1:0]           ptr;
    logic [GCW-1:0]          gap_cnt;
    logic                    first_done;
    logic                    uflag;
    logic [DATA_WIDTH-1:0]   o_data;
    logic [KEEP_WIDTH-1:0]   o_keep;
    logic                    o_valid;
    logic                    o_last;
    logic                    o_user;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    sel_user;
    logic [N_SRC-1:0]        ready;
    logic                    found;
    logic [GW-1:0]           next_grant;
    logic                    accept;
    logic                    underrun_now;
    logic                    can_grant;

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant_id == GW'(k)) begin
                sel_data  = s.tdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s.tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid = s.tvalid[k];
                sel_last  = s.tlast[k];
                sel_user  = s.tuser[k];
            end
        end
    end

    // Search starts just after the last winner, so a source with tvalid low is simply skipped.
    always_comb begin
        found      = 1'b0;
        next_grant = ptr;
        for (int i = 1; i <= N_SRC; i++) begin
            if (!found && s.tvalid[(int'(ptr) + i) % N_SRC]) begin
                found      = 1'b1;
                next_grant = GW'((int'(ptr) + i) % N_SRC);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == XFER && !rst) ready[grant_id] = ~o_valid | m.tready;
    end

    assign accept       = sel_valid & ready[grant_id];
    assign underrun_now = (state == XFER) && first_done && !o_valid && !sel_valid;
    assign can_grant    = enable && ~|dcmac_tx_af && found;

    assign s.tready  = ready;
    assign m.tdata   = o_data;
    assign m.tkeep   = o_keep;
    assign m.tvalid  = o_valid & ~rst;
    assign m.tlast   = o_last;
    assign m.tuser   = o_user;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= GW'(N_SRC - 1);
            grant_id     <= '0;
            gap_cnt      <= '0;
            first_done   <= 1'b0;
            uflag        <= 1'b0;
            o_data       <= '0;
            o_keep       <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_user       <= 1'b0;
            pkt_cnt      <= '0;
            underrun_cnt <= '0;
        end else begin
            if (accept) begin
                o_data  <= sel_data;
                o_keep  <= sel_keep;
                o_valid <= 1'b1;
                o_last  <= sel_last;
                o_user  <= sel_user | (sel_last & uflag);
            end else if (m.tready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
                o_user  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (can_grant) begin
                        grant_id   <= next_grant;
                        ptr        <= next_grant;
                        first_done <= 1'b0;
                        uflag      <= 1'b0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        first_done <= 1'b1;
                        if (sel_last) begin
                            state   <= GAP;
                            gap_cnt <= GCW'(IPG_CYC);
                            pkt_cnt <= pkt_cnt + 32'd1;
                            uflag   <= 1'b0;
                        end
                    end else if (underrun_now && !uflag) begin
                        uflag <= 1'b1;
                        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
                GAP: begin
                    // The gap is only counted once the last beat has left, so tvalid falls for real.
                    if (!o_valid) begin
                        if (gap_cnt <= GCW'(1)) state <= IDLE;
                        else                    gap_cnt <= gap_cnt - GCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fhg_tx_pkt_arbiter.sv
// Directed bench for fhg_tx_pkt_arbiter: two queued AXIS sources, an output monitor,
// and hand-computed beat order, timing and counter expectations.
module tb_fhg_tx_pkt_arbiter;
    localparam int DW = 64;
    localparam int KW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [5:0]  af = 6'h00;
    logic        m_ready = 1'b1;
    logic        grant_id;
    logic        busy;
    logic [31:0] pkt_cnt;
    logic [15:0] underrun_cnt;
    logic [1:0]  fsm_state;

    logic [DW-1:0] src_tdata [2];
    logic          src_tvalid[2];
    logic          src_tlast [2];
    logic          src_tuser [2];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic [7:0]    pre;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
        logic          gid;
        logic [31:0]   cyc;
    } obs_t;

    beat_t src_q[2][$];
    obs_t  out_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;

    fhg_tx_pkt_arbiter_if #(.N(2), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) sif ();
    fhg_tx_pkt_arbiter_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) mif ();

    assign sif.tdata  = {src_tdata[1], src_tdata[0]};
    assign sif.tkeep  = {KW'('1), KW'('1)};
    assign sif.tvalid = {src_tvalid[1], src_tvalid[0]};
    assign sif.tlast  = {src_tlast[1], src_tlast[0]};
    assign sif.tuser  = {src_tuser[1], src_tuser[0]};
    assign mif.tready = m_ready;

    fhg_tx_pkt_arbiter #(.N_SRC(2), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IPG_CYC(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .dcmac_tx_af  (af),
        .s            (sif),
        .m            (mif),
        .grant_id     (grant_id),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt),
        .underrun_cnt (underrun_cnt),
        .fsm_state    (fsm_state)
    );

    // clock/reset block
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [DW-1:0] mk(input int src, input int pkt, input int beat);
        return 64'hDA7A_0000_0000_0000 | (64'(src) << 16) | (64'(pkt) << 8) | 64'(beat);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int src, input int pkt, input int n, input int gap_at, input int gap_len);
        beat_t x;
        for (int b = 0; b < n; b++) begin
            x.data = mk(src, pkt, b);
            x.last = (b == n - 1);
            x.user = 1'b0;
            x.pre  = (b == gap_at) ? 8'(gap_len) : 8'd0;
            src_q[src].push_back(x);
        end
    endtask

    function automatic obs_t get_beat(input int i);
        if (i < out_q.size()) return out_q[i];
        return '0;
    endfunction

    // driver: presents the queue head, pops it one cycle after a handshake, flushes on reset
    task automatic src_run(input int k);
        int   gap;
        logic loaded;
        logic took;
        logic rst_s;
        gap = 0;
        loaded = 1'b0;
        forever begin
            @(negedge clk);
            took  = src_tvalid[k] && sif.tready[k];
            rst_s = rst;
            @(posedge clk);
            #1;
            if (rst_s) begin
                src_q[k].delete();
                loaded = 1'b0;
                gap = 0;
            end else if (took) begin
                void'(src_q[k].pop_front());
                loaded = 1'b0;
            end
            if (!loaded && src_q[k].size() > 0) begin
                gap = int'(src_q[k][0].pre);
                loaded = 1'b1;
            end
            if (loaded && gap == 0) begin
                src_tvalid[k] = 1'b1;
                src_tdata[k]  = src_q[k][0].data;
                src_tlast[k]  = src_q[k][0].last;
                src_tuser[k]  = src_q[k][0].user;
            end else begin
                src_tvalid[k] = 1'b0;
                src_tlast[k]  = 1'b0;
                if (gap > 0) gap--;
            end
        end
    endtask

    initial src_run(0);
    initial src_run(1);

    // monitor: logs every accepted output beat with its cycle number
    initial forever begin
        @(negedge clk);
        if (mif.tvalid && mif.tready)
            out_q.push_back('{data: mif.tdata, keep: mif.tkeep, last: mif.tlast, user: mif.tuser,
                              gid: grant_id, cyc: 32'(cyc)});
    end

    initial begin
        int   base;
        obs_t b;
        int   e2_src[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int   e2_pkt[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int   e2_cyc[8] = '{3, 4, 8, 9, 13, 14, 18, 19};
        int   e4_cyc[5] = '{3, 4, 7, 8, 9};
        for (int k = 0; k < 2; k++) begin
            src_tdata[k] = '0;
            src_tvalid[k] = 1'b0;
            src_tlast[k] = 1'b0;
            src_tuser[k] = 1'b0;
        end

        // reset state
        tick(3);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_m_tvalid", mif.tvalid, 0);
        check("rst_s_tready", sif.tready, 0);
        check("rst_state", fsm_state, 0);

        // 1: single 4-beat packet from src0, latency and framing
        base = cyc;
        push_pkt(0, 0, 4, -1, 0);
        tick(10);
        check("t1_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            b = get_beat(i);
            check($sformatf("t1_data%0d", i), b.data, mk(0, 0, i));
            check($sformatf("t1_keep%0d", i), b.keep, 8'hFF);
            check($sformatf("t1_last%0d", i), b.last, (i == 3));
            check($sformatf("t1_cyc%0d", i), b.cyc - 32'(base), 3 + i);
        end
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_idle", busy, 0);

        // 2: both sources stream back-to-back 2-beat packets from a fresh reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        out_q.delete();
        base = cyc;
        push_pkt(0, 0, 2, -1, 0);
        push_pkt(0, 1, 2, -1, 0);
        push_pkt(1, 0, 2, -1, 0);
        push_pkt(1, 1, 2, -1, 0);
        tick(24);
        check("t2_count", out_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            b = get_beat(i);
            check($sformatf("t2_data%0d", i), b.data, mk(e2_src[i], e2_pkt[i], i % 2));
            check($sformatf("t2_gid%0d", i), b.gid, e2_src[i]);
            check($sformatf("t2_last%0d", i), b.last, (i % 2 == 1));
            check($sformatf("t2_cyc%0d", i), b.cyc - 32'(base), e2_cyc[i]);
        end
        check("t2_pkt_cnt", pkt_cnt, 4);

        // 3: almost-full blocks a grant; af inside a packet is ignored
        out_q.delete();
        af = 6'h01;
        push_pkt(1, 5, 3, -1, 0);
        tick(5);
        check("t3_af_busy", busy, 0);
        check("t3_af_ready", sif.tready, 0);
        check("t3_af_count", out_q.size(), 0);
        base = cyc;
        af = 6'h00;
        tick(1);
        check("t3_grant_busy", busy, 1);
        check("t3_grant_id", grant_id, 1);
        af = 6'h3F;
        tick(6);
        check("t3_count", out_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            b = get_beat(i);
            check($sformatf("t3_data%0d", i), b.data, mk(1, 5, i));
            check($sformatf("t3_cyc%0d", i), b.cyc - 32'(base), 2 + i);
        end
        check("t3_pkt_cnt", pkt_cnt, 5);
        check("t3_end_busy", busy, 0);
        af = 6'h00;

        // 4: src0 underruns for 2 cycles before beat 3 of 5
        out_q.delete();
        base = cyc;
        push_pkt(0, 6, 5, 2, 2);
        tick(12);
        check("t4_count", out_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            b = get_beat(i);
            check($sformatf("t4_data%0d", i), b.data, mk(0, 6, i));
            check($sformatf("t4_cyc%0d", i), b.cyc - 32'(base), e4_cyc[i]);
            check($sformatf("t4_user%0d", i), b.user, (i == 4));
        end
        check("t4_underrun", underrun_cnt, 1);
        check("t4_pkt_cnt", pkt_cnt, 6);

        // 5: output back-pressure for 3 cycles mid-packet
        out_q.delete();
        base = cyc;
        push_pkt(1, 7, 4, -1, 0);
        tick(3);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_hold_valid%0d", i), mif.tvalid, 1);
            check($sformatf("t5_hold_data%0d", i), mif.tdata, mk(1, 7, 0));
            check($sformatf("t5_hold_ready%0d", i), sif.tready, 0);
            tick(1);
        end
        m_ready = 1'b1;
        tick(8);
        check("t5_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            b = get_beat(i);
            check($sformatf("t5_data%0d", i), b.data, mk(1, 7, i));
            check($sformatf("t5_cyc%0d", i), b.cyc - 32'(base), 6 + i);
        end
        check("t5_pkt_cnt", pkt_cnt, 7);
        check("t5_underrun", underrun_cnt, 1);

        // 6: reset during beat 3 of 8, then enable gating
        out_q.delete();
        push_pkt(0, 9, 8, -1, 0);
        tick(5);
        rst = 1'b1;
        #1;
        check("t6_rst_cycle_valid", mif.tvalid, 0);
        check("t6_rst_cycle_ready", sif.tready, 0);
        tick(1);
        check("t6_busy", busy, 0);
        check("t6_grant", grant_id, 0);
        check("t6_pkt_cnt", pkt_cnt, 0);
        check("t6_underrun", underrun_cnt, 0);
        check("t6_m_tvalid", mif.tvalid, 0);
        check("t6_m_tdata", mif.tdata, 0);
        rst = 1'b0;
        check("t6_count", out_q.size(), 2);
        push_pkt(1, 10, 3, -1, 0);
        tick(2);
        check("t6_en_busy", busy, 1);
        enable = 1'b0;
        push_pkt(0, 11, 2, -1, 0);
        tick(10);
        check("t6_en_idle", busy, 0);
        check("t6_en_count", out_q.size(), 5);
        check("t6_en_pkt_cnt", pkt_cnt, 1);
        b = get_beat(4);
        check("t6_en_last_data", b.data, mk(1, 10, 2));
        enable = 1'b1;
        tick(1);
        check("t6_regrant_busy", busy, 1);
        check("t6_regrant_id", grant_id, 0);
        tick(8);
        check("t6_final_count", out_q.size(), 7);
        check("t6_final_pkt_cnt", pkt_cnt, 2);
        b = get_beat(6);
        check("t6_final_data", b.data, mk(0, 11, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
